iic_reg_seq: RTL and testbench

// Register-access sequencer sitting directly upstream of the I2C byte-command master. Takes one

---
 rtl/iic_reg_seq.sv | 206 ++++++++++++++++++++
 tb/tb_iic_reg_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_reg_seq.sv
// ============================================================================
// Module      : iic_reg_seq
// Description : Register read/write sequencer driving an I2C byte-command master.
//               Optional IIC_SEQ_REG16_EN macro adds a high register-address byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iic_reg_seq #(
  parameter int TIMEOUT_CNT = 1000000
) (
  input  logic       i_SysClock,
  input  logic       i_Reset,
  input  logic       i_ReqValid,
  output logic       o_ReqReady,
  input  logic       i_ReqRead,
  input  logic [6:0] i_DevAddr,
  input  logic [15:0] i_RegAddr,
  input  logic [7:0] i_WrData,
  output logic       o_RspValid,
  output logic [7:0] o_RspData,
  output logic       o_RspNack,
  output logic       o_RspTimeout,
  output logic       o_MstCmdValid,
  output logic [3:0] o_MstCmd,
  output logic [7:0] o_MstTxByte,
  output logic       o_MstSetAck,
  input  logic       i_MstDone,
  input  logic [7:0] i_MstRxByte,
  input  logic       i_MstGetAck
);

  localparam int CNT_W = (TIMEOUT_CNT < 2) ? 1 : $clog2(TIMEOUT_CNT + 1);
  localparam logic [CNT_W-1:0] c_Limit = CNT_W'(TIMEOUT_CNT);

  typedef enum logic [2:0] {
    PH_IDLE, PH_ISSUE, PH_PULSE, PH_SKIP, PH_WAIT, PH_RSP
  } phase_t;

  typedef enum logic [3:0] {
    ST_START, ST_DEVW, ST_REGH, ST_REGL, ST_WDATA,
    ST_PRESTART, ST_START2, ST_DEVR, ST_RDATA, ST_STOP
  } step_t;

  phase_t r_Phase, w_NextPhase;
  step_t  r_Step, w_NextStep, w_SeqNext;

  logic       r_Read;
  logic [6:0] r_DevAddr;
`ifdef IIC_SEQ_REG16_EN
  logic [15:0] r_RegAddr;
`else
  logic [7:0]  r_RegAddr;
`endif
  logic [7:0] r_WrData;
  logic       r_NackFlag;
  logic [7:0] r_RdByte;
  logic [CNT_W-1:0] r_WdCnt;

  logic       w_Issue, w_SetNack, w_CaptureRd, w_TimeoutHit, w_Timeout, w_IsWrByte;
  logic [3:0] w_StepCmd;
  logic [7:0] w_StepTx;
  logic       w_StepSetAck;
  logic       w_unusedRegHigh;

  assign w_unusedRegHigh = ^i_RegAddr[15:8];
  assign o_ReqReady = (r_Phase == PH_IDLE);
  assign w_Timeout  = (TIMEOUT_CNT != 0) && (r_WdCnt == c_Limit);

  // Command encoding and successor of each step in the nominal sequence.
  always_comb begin
    w_StepCmd    = 4'd0;
    w_StepTx     = 8'h00;
    w_StepSetAck = 1'b0;
    w_IsWrByte   = 1'b0;
    w_SeqNext    = ST_STOP;
    case (r_Step)
      ST_START:    begin w_StepCmd = 4'd1; w_SeqNext = ST_DEVW; end
      ST_DEVW: begin
        w_StepCmd = 4'd2; w_StepTx = {r_DevAddr, 1'b0}; w_IsWrByte = 1'b1;
`ifdef IIC_SEQ_REG16_EN
        w_SeqNext = ST_REGH;
`else
        w_SeqNext = ST_REGL;
`endif
      end
`ifdef IIC_SEQ_REG16_EN
      ST_REGH: begin
        w_StepCmd = 4'd2; w_StepTx = r_RegAddr[15:8]; w_IsWrByte = 1'b1; w_SeqNext = ST_REGL;
      end
`endif
      ST_REGL: begin
        w_StepCmd = 4'd2; w_StepTx = r_RegAddr[7:0]; w_IsWrByte = 1'b1;
        w_SeqNext = r_Read ? ST_PRESTART : ST_WDATA;
      end
      ST_WDATA:    begin w_StepCmd = 4'd2; w_StepTx = r_WrData; w_IsWrByte = 1'b1; w_SeqNext = ST_STOP; end
      ST_PRESTART: begin w_StepCmd = 4'd5; w_SeqNext = ST_START2; end
      ST_START2:   begin w_StepCmd = 4'd1; w_SeqNext = ST_DEVR; end
      ST_DEVR: begin
        w_StepCmd = 4'd2; w_StepTx = {r_DevAddr, 1'b1}; w_IsWrByte = 1'b1; w_SeqNext = ST_RDATA;
      end
      ST_RDATA:    begin w_StepCmd = 4'd3; w_StepSetAck = 1'b1; w_SeqNext = ST_STOP; end
      ST_STOP:     begin w_StepCmd = 4'd4; w_SeqNext = ST_STOP; end
      default:     begin w_StepCmd = 4'd4; w_SeqNext = ST_STOP; end
    endcase
  end

  always_comb begin
    w_NextPhase  = r_Phase;
    w_NextStep   = r_Step;
    w_Issue      = 1'b0;
    w_SetNack    = 1'b0;
    w_CaptureRd  = 1'b0;
    w_TimeoutHit = 1'b0;
    case (r_Phase)
      PH_IDLE: if (i_ReqValid) begin
        w_NextPhase = PH_ISSUE;
        w_NextStep  = ST_START;
      end
      PH_ISSUE: if (i_MstDone) begin
        w_Issue     = 1'b1;
        w_NextPhase = PH_PULSE;
      end
      PH_PULSE: w_NextPhase = PH_SKIP;
      // Master Done is still high in this cycle from before the command.
      PH_SKIP:  w_NextPhase = PH_WAIT;
      PH_WAIT: begin
        if (i_MstDone) begin
          if (r_Step == ST_STOP) begin
            w_NextPhase = PH_RSP;
          end else if (w_IsWrByte && i_MstGetAck) begin
            w_SetNack   = 1'b1;
            w_NextStep  = ST_STOP;
            w_NextPhase = PH_ISSUE;
          end else begin
            w_CaptureRd = (r_Step == ST_RDATA);
            w_NextStep  = w_SeqNext;
            w_NextPhase = PH_ISSUE;
          end
        end else if (w_Timeout) begin
          w_TimeoutHit = 1'b1;
          w_NextPhase  = PH_RSP;
        end
      end
      PH_RSP:  w_NextPhase = PH_IDLE;
      default: w_NextPhase = PH_IDLE;
    endcase
  end

  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      r_Phase       <= PH_IDLE;
      r_Step        <= ST_START;
      r_Read        <= 1'b0;
      r_DevAddr     <= '0;
      r_RegAddr     <= '0;
      r_WrData      <= '0;
      r_NackFlag    <= 1'b0;
      r_RdByte      <= '0;
      r_WdCnt       <= '0;
      o_MstCmdValid <= 1'b0;
      o_MstCmd      <= 4'd0;
      o_MstTxByte   <= 8'h00;
      o_MstSetAck   <= 1'b0;
      o_RspValid    <= 1'b0;
      o_RspData     <= 8'h00;
      o_RspNack     <= 1'b0;
      o_RspTimeout  <= 1'b0;
    end else begin
      r_Phase <= w_NextPhase;
      r_Step  <= w_NextStep;
      if (r_Phase == PH_IDLE && i_ReqValid) begin
        r_Read     <= i_ReqRead;
        r_DevAddr  <= i_DevAddr;
`ifdef IIC_SEQ_REG16_EN
        r_RegAddr  <= i_RegAddr;
`else
        r_RegAddr  <= i_RegAddr[7:0];
`endif
        r_WrData   <= i_WrData;
        r_NackFlag <= 1'b0;
        r_RdByte   <= 8'h00;
      end
      o_MstCmdValid <= w_Issue;
      if (w_Issue) begin
        o_MstCmd    <= w_StepCmd;
        o_MstTxByte <= w_StepTx;
        o_MstSetAck <= w_StepSetAck;
        r_WdCnt     <= '0;
      end else if ((r_Phase == PH_SKIP || r_Phase == PH_WAIT) && r_WdCnt < c_Limit) begin
        r_WdCnt <= r_WdCnt + 1'b1;
      end
      if (w_SetNack)   r_NackFlag <= 1'b1;
      if (w_CaptureRd) r_RdByte   <= i_MstRxByte;
      o_RspValid <= (w_NextPhase == PH_RSP);
      if (w_NextPhase == PH_RSP) begin
        o_RspTimeout <= w_TimeoutHit;
        o_RspNack    <= r_NackFlag & ~w_TimeoutHit;
        o_RspData    <= (w_TimeoutHit || r_NackFlag) ? 8'h00 : r_RdByte;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iic_reg_seq.sv
// ============================================================================
// Module      : tb_iic_reg_seq
// Description : Randomized bench for iic_reg_seq with a behavioural I2C master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iic_reg_seq;

  localparam int c_To = 300;

  logic i_SysClock = 1'b0;
  logic i_Reset = 1'b1;
  logic i_ReqValid = 1'b0, i_ReqRead = 1'b0;
  logic [6:0] i_DevAddr = '0;
  logic [15:0] i_RegAddr = '0;
  logic [7:0] i_WrData = '0;
  logic i_MstDone = 1'b1, i_MstGetAck = 1'b0;
  logic [7:0] i_MstRxByte = '0;
  logic o_ReqReady, o_RspValid, o_RspNack, o_RspTimeout, o_MstCmdValid, o_MstSetAck;
  logic [7:0] o_RspData, o_MstTxByte;
  logic [3:0] o_MstCmd;

  iic_reg_seq #(.TIMEOUT_CNT(c_To)) dut (
    .i_SysClock(i_SysClock), .i_Reset(i_Reset), .i_ReqValid(i_ReqValid), .o_ReqReady(o_ReqReady),
    .i_ReqRead(i_ReqRead), .i_DevAddr(i_DevAddr), .i_RegAddr(i_RegAddr), .i_WrData(i_WrData),
    .o_RspValid(o_RspValid), .o_RspData(o_RspData), .o_RspNack(o_RspNack),
    .o_RspTimeout(o_RspTimeout), .o_MstCmdValid(o_MstCmdValid), .o_MstCmd(o_MstCmd),
    .o_MstTxByte(o_MstTxByte), .o_MstSetAck(o_MstSetAck), .i_MstDone(i_MstDone),
    .i_MstRxByte(i_MstRxByte), .i_MstGetAck(i_MstGetAck)
  );

  always #5 i_SysClock = ~i_SysClock;

  int errCnt = 0, chkCnt = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Master/slave model state and observation records
  logic [12:0] obsQ[$];
  logic [12:0] expQ[$];
  int accCnt = 0, rspCnt = 0, cyc = 0, lastCmdCyc = 0, rspCyc = 0;
  int mByteIdx = 0, mCmdIdx = 0, mBusy = 0;
  int mNackAt = -1, mStuckAt = -1;
  logic [7:0] mRd = '0, mResRx = '0;
  bit mPending = 0, mStuck = 0, mResAck = 0;

  initial begin
    forever begin
      @(negedge i_SysClock);
      cyc++;
      if (i_Reset) begin
        i_MstDone = 1'b1; mPending = 0; mStuck = 0; mBusy = 0;
      end else begin
        if (i_ReqValid && o_ReqReady) begin
          accCnt++; mByteIdx = 0; mCmdIdx = 0;
        end
        if (o_RspValid) begin
          rspCnt++; rspCyc = cyc;
          if (mStuck) begin mStuck = 0; mPending = 0; i_MstDone = 1'b1; end
        end
        if (mPending) begin
          i_MstDone = 1'b0; mPending = 0;
        end else if (!i_MstDone && !mStuck) begin
          if (mBusy == 0) begin
            i_MstDone = 1'b1; i_MstGetAck = mResAck; i_MstRxByte = mResRx;
          end else mBusy--;
        end
        if (o_MstCmdValid) begin
          obsQ.push_back({o_MstCmd, o_MstTxByte, o_MstSetAck});
          lastCmdCyc = cyc;
          mResAck = 1'($urandom_range(0, 1));
          mResRx  = 8'($urandom);
          if (o_MstCmd == 4'd2) begin mResAck = (mByteIdx == mNackAt); mByteIdx++; end
          if (o_MstCmd == 4'd3) mResRx = mRd;
          mStuck = (mCmdIdx == mStuckAt);
          mCmdIdx++;
          mBusy = $urandom_range(0, 4);
          if ($urandom_range(0, 1) == 1) mPending = 1; else i_MstDone = 1'b0;
        end
      end
    end
  end

  // Expected command stream from the protocol rules, as {cmd, txbyte, setack}.
  task automatic buildExpected(input bit rd, input logic [6:0] dev, input logic [15:0] ra,
                               input logic [7:0] wd, input logic [7:0] rdv, input int nackAt,
                               output bit expNack, output logic [7:0] expData);
    logic [7:0] wb[$];
    int k;
    expQ.delete();
    expNack = 0;
    expQ.push_back({4'd1, 8'h00, 1'b0});
    wb.push_back({dev, 1'b0});
`ifdef IIC_SEQ_REG16_EN
    wb.push_back(ra[15:8]);
`endif
    wb.push_back(ra[7:0]);
    if (!rd) wb.push_back(wd);
    k = 0;
    while (k < wb.size() && !expNack) begin
      expQ.push_back({4'd2, wb[k], 1'b0});
      if (k == nackAt) expNack = 1;
      k++;
    end
    if (rd && !expNack) begin
      expQ.push_back({4'd5, 8'h00, 1'b0});
      expQ.push_back({4'd1, 8'h00, 1'b0});
      expQ.push_back({4'd2, {dev, 1'b1}, 1'b0});
      if (k == nackAt) expNack = 1;
      else expQ.push_back({4'd3, 8'h00, 1'b1});
    end
    expQ.push_back({4'd4, 8'h00, 1'b0});
    expData = (rd && !expNack) ? rdv : 8'h00;
  endtask

  task automatic runTxn(input bit rd, input logic [6:0] dev, input logic [15:0] ra,
                        input logic [7:0] wd, input logic [7:0] rdv, input int nackAt,
                        input int stuckAt);
    bit expNack, expTo, got;
    logic [7:0] expData, gotData;
    logic gotNack, gotTo;
    int obs0, acc0, rsp0, n;
    buildExpected(rd, dev, ra, wd, rdv, nackAt, expNack, expData);
    expTo = 0;
    if (stuckAt >= 0) begin
      while (expQ.size() > stuckAt + 1) void'(expQ.pop_back());
      expNack = 0; expData = 8'h00; expTo = 1;
    end
    mNackAt = nackAt; mRd = rdv; mStuckAt = stuckAt;
    obs0 = obsQ.size(); acc0 = accCnt; rsp0 = rspCnt;
    @(posedge i_SysClock); #2;
    i_ReqRead = rd; i_DevAddr = dev; i_RegAddr = ra; i_WrData = wd; i_ReqValid = 1'b1;
    got = 0; gotData = '0; gotNack = 0; gotTo = 0;
    for (int i = 0; i < 2 * c_To + 500; i++) begin
      @(negedge i_SysClock);
      if (o_RspValid) begin
        got = 1; gotData = o_RspData; gotNack = o_RspNack; gotTo = o_RspTimeout;
        break;
      end
    end
    checkEq("rsp_seen", 32'(got), 32'd1);
    @(posedge i_SysClock); #2;
    i_ReqValid = 1'b0;
    @(negedge i_SysClock);
    checkEq("ready_after_rsp", 32'(o_ReqReady), 32'd1);
    checkEq("rspdata_held", 32'(o_RspData), 32'(expData));
    repeat (2) @(negedge i_SysClock);
    checkEq("accepts", 32'(accCnt - acc0), 32'd1);
    checkEq("rsp_pulses", 32'(rspCnt - rsp0), 32'd1);
    checkEq("rsp_nack", 32'(gotNack), 32'(expNack));
    checkEq("rsp_timeout", 32'(gotTo), 32'(expTo));
    checkEq("rsp_data", 32'(gotData), 32'(expData));
    n = obsQ.size() - obs0;
    checkEq("cmd_count", 32'(n), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < n; i++) begin
      checkEq("cmd", 32'(obsQ[obs0+i][12:9]), 32'(expQ[i][12:9]));
      checkEq("setack", 32'(obsQ[obs0+i][0]), 32'(expQ[i][0]));
      if (expQ[i][12:9] == 4'd2) checkEq("txbyte", 32'(obsQ[obs0+i][8:1]), 32'(expQ[i][8:1]));
    end
    if (stuckAt >= 0)
      checkEq("to_latency", 32'((rspCyc - lastCmdCyc >= c_To) && (rspCyc - lastCmdCyc <= c_To + 5)), 32'd1);
    mStuckAt = -1;
  endtask

  initial begin
    int obs0, rsp0, nk, st, bsz;
    bit rd, dn;
    logic [7:0] dd;
    logic [6:0] dev;
    logic [15:0] ra;
    logic [7:0] wd, rdv;

    repeat (3) @(posedge i_SysClock);
    @(negedge i_SysClock);
    checkEq("rst_ready", 32'(o_ReqReady), 32'd1);
    checkEq("rst_rspvalid", 32'(o_RspValid), 32'd0);
    checkEq("rst_rspnack", 32'(o_RspNack), 32'd0);
    checkEq("rst_rsptimeout", 32'(o_RspTimeout), 32'd0);
    checkEq("rst_rspdata", 32'(o_RspData), 32'd0);
    checkEq("rst_cmdvalid", 32'(o_MstCmdValid), 32'd0);
    checkEq("rst_cmd", 32'(o_MstCmd), 32'd0);
    checkEq("rst_txbyte", 32'(o_MstTxByte), 32'd0);
    checkEq("rst_setack", 32'(o_MstSetAck), 32'd0);
    @(posedge i_SysClock); #2;
    i_Reset = 1'b0;

    runTxn(0, 7'h50, 16'h0012, 8'hA5, 8'h00, -1, -1);
    runTxn(1, 7'h50, 16'h0034, 8'h00, 8'h5A, -1, -1);
    runTxn(0, 7'h21, 16'h0012, 8'h33, 8'h00, 0, -1);
    runTxn(0, 7'h50, 16'hBEEF, 8'h01, 8'h00, -1, -1);
    runTxn(1, 7'h50, 16'h0034, 8'h00, 8'h77, 2, -1);
    runTxn(0, 7'h50, 16'h0012, 8'hA5, 8'h00, -1, 2);

    for (int t = 0; t < 40; t++) begin
      rd  = 1'($urandom_range(0, 1));
      dev = 7'($urandom);
      ra  = 16'($urandom);
      wd  = 8'($urandom);
      rdv = 8'($urandom);
      nk  = $urandom_range(0, 7);
      if (nk > 4) nk = -1;
      st = -1;
      if ($urandom_range(0, 7) == 0) begin
        buildExpected(rd, dev, ra, wd, rdv, -1, dn, dd);
        bsz = expQ.size();
        st = $urandom_range(0, bsz - 1);
        nk = -1;
      end
      runTxn(rd, dev, ra, wd, rdv, nk, st);
    end

    // Reset in the middle of a transaction abandons it silently.
    mNackAt = -1; mStuckAt = -1;
    obs0 = obsQ.size();
    @(posedge i_SysClock); #2;
    i_ReqRead = 1'b0; i_DevAddr = 7'h50; i_RegAddr = 16'h0012; i_WrData = 8'hC3; i_ReqValid = 1'b1;
    for (int i = 0; i < 200 && obsQ.size() < obs0 + 2; i++) @(negedge i_SysClock);
    checkEq("midrst_started", 32'(obsQ.size() >= obs0 + 2), 32'd1);
    @(posedge i_SysClock); #2;
    i_Reset = 1'b1; i_ReqValid = 1'b0;
    rsp0 = rspCnt;
    @(posedge i_SysClock);
    @(negedge i_SysClock);
    checkEq("midrst_ready", 32'(o_ReqReady), 32'd1);
    checkEq("midrst_cmdvalid", 32'(o_MstCmdValid), 32'd0);
    checkEq("midrst_rspvalid", 32'(o_RspValid), 32'd0);
    @(posedge i_SysClock); #2;
    i_Reset = 1'b0;
    repeat (30) @(negedge i_SysClock);
    checkEq("midrst_no_rsp", 32'(rspCnt - rsp0), 32'd0);
    runTxn(1, 7'h50, 16'h0034, 8'h00, 8'h5A, -1, -1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

`default_nettype wire
